// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by both the BCD-to-binary converter and the binary-to-BCD encoder.
package bcd_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_BIN_W  = 15;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd8;
    localparam bcd_digit_t BCD_ADJ        = 4'd3;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } bcd_state_t;

    function automatic logic bcd_digit_bad(input bcd_digit_t d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for the reverse double-dabble: digits of 8 or more lose 3 after each shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= BCD_ADJ_THRESH) ? d - BCD_ADJ : d;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: one shift/adjust iteration per clock under a start/done handshake.
module bcd2bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = BCD_DIGITS,
    parameter int BIN_W  = BCD_BIN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      binary,
    output logic                  err
);

    localparam int W_W   = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    bcd_state_t         state, state_nx;
    logic [W_W-1:0]     work, work_nx, shifted, adjusted;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               busy_nx, done_nx, err_nx;
    logic [BIN_W-1:0]   binary_nx;
    logic               any_bad;

    // Low binary bits pass straight through; only the BCD digit fields are corrected.
    assign shifted                 = work >> 1;
    assign adjusted[BIN_W-1:0]     = shifted[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (shifted[BIN_W + 4*g +: 4]),
            .q (adjusted[BIN_W + 4*g +: 4])
        );
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_digit_bad(bcd_in[4*i +: 4])) any_bad = 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        work_nx   = work;
        cnt_nx    = cnt;
        busy_nx   = busy;
        done_nx   = 1'b0;
        binary_nx = binary;
        err_nx    = err;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (any_bad) begin
                        binary_nx = '0;
                        err_nx    = 1'b1;
                        done_nx   = 1'b1;
                    end else begin
                        work_nx  = {bcd_in, {BIN_W{1'b0}}};
                        cnt_nx   = '0;
                        err_nx   = 1'b0;
                        busy_nx  = 1'b1;
                        state_nx = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_nx = adjusted;
                cnt_nx  = cnt + 1'b1;
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    binary_nx = adjusted[BIN_W-1:0];
                    done_nx   = 1'b1;
                    busy_nx   = 1'b0;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            binary <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            work   <= work_nx;
            cnt    <= cnt_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            binary <= binary_nx;
            err    <= err_nx;
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: the driver queues expected results, a negedge monitor checks each done.
module tb_bcd2bin;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        busy, done, err;
    logic [14:0] binary;

    bcd2bin #(.DIGITS(4), .BIN_W(15)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .binary (binary),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] bin;
        logic        err;
        int          cyc;
        logic [15:0] code;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] code, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s code=%h: got %0d, required %0d", name, code, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: binary=%0d err=%b, required no done", binary, err);
            end else begin
                e = sb.pop_front();
                chk("binary",  e.code, int'(binary), int'(e.bin));
                chk("err",     e.code, int'(err),    int'(e.err));
                chk("latency", e.code, cyc,          e.cyc);
                chk("busy_at_done", e.code, int'(busy), 0);
                if (!e.err) chk("bcd_field_zero", e.code, int'(dut.work[29:15]) | int'(dut.work[30]), 0);
            end
        end
    end

    task automatic wait_drain(output bit seen_busy);
        bit drained;
        seen_busy = 1'b0;
        drained   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            seen_busy |= busy;
            if (sb.size() == 0) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!drained) begin
            n_fail++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [15:0] code, input logic [14:0] eb, input logic ee);
        bit seen_busy;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = code;
        sb.push_back('{eb, ee, cyc + (ee ? 1 : 16), code});
        @(negedge clk);
        start = 1'b0;
        wait_drain(seen_busy);
        if (ee) chk("busy_never_on_invalid", code, int'(seen_busy), 0);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sb_dummy;
        int c;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_busy",   16'h0, int'(busy),   0);
        chk("reset_done",   16'h0, int'(done),   0);
        chk("reset_binary", 16'h0, int'(binary), 0);
        chk("reset_err",    16'h0, int'(err),    0);

        run(16'h1234, 15'h04D2, 1'b0);
        run(16'h9999, 15'h270F, 1'b0);
        run(16'h0000, 15'h0000, 1'b0);
        run(16'h12A4, 15'h0000, 1'b1);
        run(16'h0042, 15'h002A, 1'b0);
        run(16'hA000, 15'h0000, 1'b1);
        run(16'h0B00, 15'h0000, 1'b1);
        run(16'h00C0, 15'h0000, 1'b1);
        run(16'h000F, 15'h0000, 1'b1);
        run(16'h0042, 15'h002A, 1'b0);

        // Extra start pulses mid-conversion must not launch a second conversion.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0500;
        sb.push_back('{15'h01F4, 1'b0, cyc + 16, 16'h0500});
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0777;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'h0000;
        wait_drain(sb_dummy);
        repeat (20) @(negedge clk);

        // Start held high: acceptances 16 cycles apart.
        @(negedge clk);
        c      = cyc;
        start  = 1'b1;
        bcd_in = 16'h0001;
        sb.push_back('{15'd1,   1'b0, c + 16, 16'h0001});
        sb.push_back('{15'd10,  1'b0, c + 32, 16'h0010});
        sb.push_back('{15'd100, 1'b0, c + 48, 16'h0100});
        @(negedge clk);
        bcd_in = 16'h0010;
        while (cyc < c + 17) @(negedge clk);
        bcd_in = 16'h0100;
        while (cyc < c + 33) @(negedge clk);
        start = 1'b0;
        wait_drain(sb_dummy);
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-conversion drops the request without a done.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h8765;
        sb.push_back('{15'h223D, 1'b0, cyc + 16, 16'h8765});
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   16'h8765, int'(busy),   0);
        chk("abort_done",   16'h8765, int'(done),   0);
        chk("abort_binary", 16'h8765, int'(binary), 0);
        chk("abort_err",    16'h8765, int'(err),    0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run(16'h8765, 15'h223D, 1'b0);

        // Sweep of valid codes against the decimal value they encode.
        for (int v = 0; v < 10000; v += 7) run(to_bcd(v), 15'(v), 1'b0);
        run(to_bcd(9999), 15'd9999, 1'b0);
        run(16'hFFFF, 15'h0000, 1'b1);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
